// File: rtl/rns_reverse_converter.sv
// rns_reverse_converter: sequential {2^N-1, 2^N, 2^N+1} residue triple to binary converter
module rns_reverse_converter #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   r1,
  input  logic [N-1:0]   r2,
  input  logic [N:0]     r3,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [3*N-1:0] out_x,
  output logic           out_err
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PREP = 3'd1;
  localparam logic [2:0] DBL  = 3'd2;
  localparam logic [2:0] COMB = 3'd3;
  localparam logic [2:0] OUT  = 3'd4;
  localparam logic [N-1:0] P1 = {N{1'b1}};
  localparam logic [N:0] P3 = {1'b1, {(N-1){1'b0}}, 1'b1};
  localparam logic [N:0] TOP3 = {1'b1, {N{1'b0}}};
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic [N-1:0] r1_q, r2_q, a_q;
  logic [N:0] r3_q, d_q;
  logic err_q;
  logic [N-1:0] r1_z, r2_z, a_n;
  logic [N:0] r2_e, a_e, b_n, d_n, d2_n;
  logic [N+1:0] dd, ds;
  logic [2*N:0] z_w;
  assign in_ready = (state == IDLE);
  // modular residue differences, one doubling step and the final Z = a + k*(2^N-1)
  always_comb begin
    r1_z = (r1_q == P1) ? '0 : r1_q;
    r2_z = (r2_q == P1) ? '0 : r2_q;
    a_n  = (r1_z >= r2_z) ? r1_z - r2_z : r1_z + P1 - r2_z;
    r2_e = {1'b0, r2_q};
    a_e  = {1'b0, a_n};
    b_n  = (r2_e >= r3_q) ? r2_e - r3_q : r2_e + P3 - r3_q;
    d_n  = (b_n >= a_e) ? b_n - a_e : b_n + P3 - a_e;
    dd   = {d_q, 1'b0};
    ds   = dd - {1'b0, P3};
    d2_n = (dd >= {1'b0, P3}) ? ds[N:0] : dd[N:0];
    z_w  = {{(N+1){1'b0}}, a_q} + {d_q, {N{1'b0}}} - {{N{1'b0}}, d_q};
  end
  // conversion sequencer: latch, prepare, N-1 doublings, combine, hold result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      r3_q      <= '0;
      a_q       <= '0;
      d_q       <= '0;
      err_q     <= 1'b0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          r1_q  <= r1;
          r2_q  <= r2;
          r3_q  <= r3;
          state <= PREP;
        end
        PREP: begin
          a_q   <= a_n;
          d_q   <= d_n;
          cnt   <= CW'(N - 1);
          err_q <= (r3_q > TOP3);
          state <= (r3_q > TOP3) ? COMB : DBL;
        end
        DBL: begin
          d_q   <= d2_n;
          cnt   <= cnt - 1'b1;
          state <= (cnt == CW'(1)) ? COMB : DBL;
        end
        COMB: begin
          out_x     <= err_q ? '0 : {z_w[2*N-1:0], r2_q};
          out_err   <= err_q;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rns_reverse_converter.sv
// tb_rns_reverse_converter: randomized and directed checks of the RNS reverse converter against a CRT reference
module tb_rns_reverse_converter;
  localparam int N = 8;
  localparam int M = 16776960;
  localparam int LAT = N + 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [N-1:0] r1 = '0;
  logic [N-1:0] r2 = '0;
  logic [N:0] r3 = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [3*N-1:0] out_x;
  logic out_err;
  int tests = 0;
  int fails = 0;

  rns_reverse_converter #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .r1(r1), .r2(r2), .r3(r3), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // latency counts clock edges from the accept edge (edge 1) to the edge raising out_valid
  task automatic run(input logic [N-1:0] a1, input logic [N-1:0] a2, input logic [N:0] a3,
                     input int stall, input bit junk,
                     output logic [3*N-1:0] x, output logic e, output int lat, output bit held);
    @(negedge clk);
    in_valid = 1'b1; r1 = a1; r2 = a2; r3 = a3;
    held = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0; r1 = '0; r2 = '0; r3 = '0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    x = out_x;
    e = out_err;
    for (int i = 0; i < stall; i++) begin
      if (junk) begin
        in_valid = 1'b1;
        r1 = N'($urandom); r2 = N'($urandom); r3 = (N+1)'($urandom_range(0, 256));
      end
      @(posedge clk);
      @(negedge clk);
      if (out_x !== x || out_err !== e || out_valid !== 1'b1 || in_ready !== 1'b0) held = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++; if (out_x !== '0) begin fails++; $display("FAIL reset_out_x got=%0d exp=0", out_x); end
    tests++; if (out_err !== 1'b0) begin fails++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
    rst = 1'b0;
  endtask

  task automatic test_known();
    logic [N-1:0] t1 [4] = '{8'd145, 8'd0, 8'd255, 8'd254};
    logic [N-1:0] t2 [4] = '{8'd64, 8'd0, 8'd0, 8'd255};
    logic [N:0]   t3 [4] = '{9'd13, 9'd0, 9'd0, 9'd256};
    int           tx [4] = '{1000000, 0, 0, 16776959};
    logic [3*N-1:0] x; logic e; int lat; bit held;
    for (int i = 0; i < 4; i++) begin
      run(t1[i], t2[i], t3[i], 0, 1'b0, x, e, lat, held);
      tests++; if (x !== 24'(tx[i])) begin fails++; $display("FAIL known_x[%0d] got=%0d exp=%0d", i, x, tx[i]); end
      tests++; if (e !== 1'b0) begin fails++; $display("FAIL known_err[%0d] got=%b exp=0", i, e); end
      tests++; if (lat != LAT) begin fails++; $display("FAIL known_latency[%0d] got=%0d exp=%0d", i, lat, LAT); end
    end
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL known_release got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
  endtask

  task automatic test_error();
    logic [3*N-1:0] x; logic e; int lat; bit held;
    run(8'd10, 8'd20, 9'd300, 0, 1'b0, x, e, lat, held);
    tests++; if (lat >= 40) begin fails++; $display("FAIL err_timeout got=%0d edges exp=<40", lat); end
    tests++; if (e !== 1'b1) begin fails++; $display("FAIL err_flag got=%b exp=1", e); end
    tests++; if (x !== '0) begin fails++; $display("FAIL err_x got=%0d exp=0", x); end
    run(8'd145, 8'd64, 9'd13, 0, 1'b0, x, e, lat, held);
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL err_clear got=%b exp=0", e); end
    tests++; if (x !== 24'd1000000) begin fails++; $display("FAIL err_next_x got=%0d exp=1000000", x); end
  endtask

  task automatic test_backpressure();
    logic [3*N-1:0] x; logic e; int lat; bit held;
    int v;
    for (int k = 0; k < 2; k++) begin
      v = int'($urandom_range(0, M - 1));
      run(N'(v % 255), N'(v % 256), (N+1)'(v % 257), 5, 1'b1, x, e, lat, held);
      tests++; if (!held) begin fails++; $display("FAIL bp_hold[%0d] got=unstable exp=stable", k); end
      tests++; if (x !== 24'(v)) begin fails++; $display("FAIL bp_x[%0d] got=%0d exp=%0d", k, x, v); end
      tests++; if (lat != LAT) begin fails++; $display("FAIL bp_latency[%0d] got=%0d exp=%0d", k, lat, LAT); end
    end
  endtask

  task automatic test_reset_mid();
    logic [3*N-1:0] x; logic e; int lat; bit held;
    @(negedge clk);
    in_valid = 1'b1; r1 = 8'd145; r2 = 8'd64; r3 = 9'd13;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_no_partial got=%b exp=0", out_valid); end
    run(8'd254, 8'd255, 9'd256, 0, 1'b0, x, e, lat, held);
    tests++; if (x !== 24'd16776959) begin fails++; $display("FAIL midrst_next_x got=%0d exp=16776959", x); end
    tests++; if (lat != LAT) begin fails++; $display("FAIL midrst_latency got=%0d exp=%0d", lat, LAT); end
  endtask

  task automatic test_random();
    logic [3*N-1:0] x; logic e; int lat; bit held;
    int v, f0;
    f0 = fails;
    for (int k = 0; k < 2000; k++) begin
      v = int'($urandom_range(0, M - 1));
      run(N'(v % 255), N'(v % 256), (N+1)'(v % 257), int'($urandom_range(0, 3)), 1'b0, x, e, lat, held);
      tests++; if (x !== 24'(v) || e !== 1'b0) begin fails++; if (fails - f0 < 10) $display("FAIL rand_x[%0d] got=%0d/%b exp=%0d/0", k, x, e, v); end
      tests++; if (lat != LAT) begin fails++; if (fails - f0 < 10) $display("FAIL rand_latency[%0d] got=%0d exp=%0d", k, lat, LAT); end
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_error();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
